// File: rtl/imem_fetch_ctrl_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and state encoding for the instruction fetch
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int ADDR_W      = 8;
    localparam int INSTR_BYTES = 4;
    localparam int PC_INC      = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
// ============================================================================
// Module      : imem_fetch_ctrl_if
// Description : Bundle of the IF/ID handshake, redirect, memory port and
//               loader signals around the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_fetch_ctrl_if;
    import imem_pkg::*;

    logic              run;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              align_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ready;

    modport master (
        input  run, redirect_valid, redirect_pc, instr_ready, mem_rdata,
               ld_valid, ld_addr, ld_data,
        output instr_valid, instr, instr_pc, align_err, mem_en, mem_we,
               mem_addr, mem_wdata, ld_ready
    );

    modport slave (
        output run, redirect_valid, redirect_pc, instr_ready, mem_rdata,
               ld_valid, ld_addr, ld_data,
        input  instr_valid, instr, instr_pc, align_err, mem_en, mem_we,
               mem_addr, mem_wdata, ld_ready
    );

endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Byte-serial instruction fetch sequencer: four reads per word,
//               big-endian assembly, valid/ready delivery, redirects, and a
//               loader write path while halted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    imem_fetch_ctrl_if.master bus
);

    localparam logic [1:0] c_LAST_BYTE = 2'(INSTR_BYTES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_redir_pc;

    logic [1:0]        r_issue_cnt;
    logic              r_issue_done;
    logic [1:0]        r_cap_cnt;
    logic              r_rd_pending;
    logic [23:0]       r_shift;

    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_align_err;

    logic              w_redir_act;
    logic              w_handshake;
    logic              w_fetch_rd;
    logic              w_last_cap;
    logic              w_ld_ready;
    logic              w_ld_wr;

    assign w_redir_pc  = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_redir_act = bus.redirect_valid & (r_state != ST_HALT);
    assign w_handshake = r_instr_valid & bus.instr_ready;
    assign w_fetch_rd  = (r_state == ST_FETCH) & ~r_issue_done;
    assign w_last_cap  = (r_state == ST_FETCH) & r_rd_pending & (r_cap_cnt == c_LAST_BYTE);

    // Loader may only own the port while fully halted and not about to start.
    assign w_ld_ready  = rst_n & (r_state == ST_HALT) & ~bus.run;
    assign w_ld_wr     = bus.ld_valid & w_ld_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_HALT: begin
                if (bus.redirect_valid) w_pc_nxt = w_redir_pc;
                if (bus.run)            w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_redir_act) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = bus.run ? ST_FETCH : ST_HALT;
                end else if (w_last_cap) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_redir_act) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = bus.run ? ST_FETCH : ST_HALT;
                end else if (w_handshake) begin
                    w_pc_nxt    = r_pc + ADDR_W'(PC_INC);
                    w_state_nxt = bus.run ? ST_FETCH : ST_HALT;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt   <= 2'd0;
            r_issue_done  <= 1'b0;
            r_cap_cnt     <= 2'd0;
            r_rd_pending  <= 1'b0;
            r_shift       <= 24'd0;
            r_instr       <= 32'd0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_align_err   <= 1'b0;
        end else begin
            r_align_err  <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
            // A read issued in the redirect cycle returns stale data; drop it.
            r_rd_pending <= w_fetch_rd & ~w_redir_act;

            if (w_redir_act || (r_state != ST_FETCH)) begin
                r_issue_cnt  <= 2'd0;
                r_issue_done <= 1'b0;
                r_cap_cnt    <= 2'd0;
            end else begin
                if (w_fetch_rd) begin
                    r_issue_cnt <= r_issue_cnt + 2'd1;
                    if (r_issue_cnt == c_LAST_BYTE) r_issue_done <= 1'b1;
                end
                if (r_rd_pending) begin
                    r_shift   <= {r_shift[15:0], bus.mem_rdata};
                    r_cap_cnt <= r_cap_cnt + 2'd1;
                end
                if (w_last_cap) r_issue_done <= 1'b0;
            end

            if (w_last_cap && !w_redir_act) begin
                r_instr       <= {r_shift, bus.mem_rdata};
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end else if (w_redir_act || w_handshake) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.align_err   = r_align_err;
    assign bus.ld_ready    = w_ld_ready;
    assign bus.mem_en      = w_fetch_rd | w_ld_wr;
    assign bus.mem_we      = w_ld_wr;
    assign bus.mem_wdata   = w_ld_wr ? bus.ld_data : 8'd0;
    assign bus.mem_addr    = w_ld_wr    ? bus.ld_addr :
                             w_fetch_rd ? (r_pc + {{(ADDR_W-2){1'b0}}, r_issue_cnt}) :
                                          '0;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Directed plus randomized bench for imem_fetch_ctrl with a
//               byte memory and a word-level expected-PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    logic [7:0] mem [256];

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: read data appears the cycle after the request.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
        else                           bus.mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    task automatic wait_valid(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (bus.instr_valid === 1'b1) return;
        end
        chk(tag, 32'(bus.instr_valid), 32'd1);
    endtask

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] rpc;
        logic       redir;
        logic       prev_redir;
        logic       prev_unal;
        int         idle;
        logic [31:0] held;

        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE8; mem[1] = 8'h1F; mem[2] = 8'h1F; mem[3] = 8'hFD;
        mem[4] = 8'h08; mem[5] = 8'h00; mem[6] = 8'h02; mem[7] = 8'h5A;

        rst_n              = 1'b0;
        bus.run            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.instr_ready    = 1'b0;
        bus.ld_valid       = 1'b0;
        bus.ld_addr        = 8'h00;
        bus.ld_data        = 8'h00;

        cyc(); cyc();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc",    32'(bus.instr_pc), 32'd0);
        chk("rst_align", 32'(bus.align_err), 32'd0);
        chk("rst_en",    32'(bus.mem_en), 32'd0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        rst_n = 1'b1;

        // First word: issue timing, 5-cycle latency, then a 10-cycle stall.
        cyc();
        bus.run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("issue_en",   32'(bus.mem_en), 32'd1);
            chk("issue_we",   32'(bus.mem_we), 32'd0);
            chk("issue_addr", 32'(bus.mem_addr), 32'(k));
        end
        cyc();
        chk("lat_notyet", 32'(bus.instr_valid), 32'd0);
        cyc();
        chk("w0_valid", 32'(bus.instr_valid), 32'd1);
        chk("w0_instr", bus.instr, 32'hE81F1FFD);
        chk("w0_pc",    32'(bus.instr_pc), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_instr", bus.instr, 32'hE81F1FFD);
            chk("stall_noen",  32'(bus.mem_en), 32'd0);
        end
        bus.instr_ready = 1'b1;
        cyc();
        chk("hs_drop",  32'(bus.instr_valid), 32'd0);
        chk("hs_en",    32'(bus.mem_en), 32'd1);
        chk("hs_addr",  32'(bus.mem_addr), 32'd4);
        wait_valid(10, "w1_timeout");
        chk("w1_instr", bus.instr, 32'h0800025A);
        chk("w1_pc",    32'(bus.instr_pc), 32'd4);

        // Unaligned redirect while byte 2 of the word at 8 is being issued.
        cyc(); cyc(); cyc();
        chk("b2_addr", 32'(bus.mem_addr), 32'h0A);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h42;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("rd_addr",  32'(bus.mem_addr), 32'h40);
        chk("rd_en",    32'(bus.mem_en), 32'd1);
        chk("rd_valid", 32'(bus.instr_valid), 32'd0);
        chk("rd_align", 32'(bus.align_err), 32'd1);
        cyc();
        chk("rd_align_once", 32'(bus.align_err), 32'd0);
        chk("rd_valid2",     32'(bus.instr_valid), 32'd0);
        wait_valid(10, "w40_timeout");
        chk("w40_pc",    32'(bus.instr_pc), 32'h40);
        chk("w40_instr", bus.instr, word_at(8'h40));

        // PC wrap from 252 back to 0.
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFC;
        cyc();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", 32'(bus.mem_addr), 32'(8'hFC + k));
            cyc();
        end
        wait_valid(10, "wFC_timeout");
        chk("wFC_pc",    32'(bus.instr_pc), 32'hFC);
        chk("wFC_instr", bus.instr, word_at(8'hFC));
        cyc();
        chk("wrap0_en",   32'(bus.mem_en), 32'd1);
        chk("wrap0_addr", 32'(bus.mem_addr), 32'd0);
        wait_valid(10, "wrap0_timeout");
        chk("wrap0_pc",    32'(bus.instr_pc), 32'd0);
        chk("wrap0_instr", bus.instr, 32'hE81F1FFD);

        // Halt mid-fetch, then a loader write, then restart from the loaded byte.
        cyc();
        bus.run = 1'b0;
        wait_valid(10, "halt_word_timeout");
        chk("halt_word_pc",    32'(bus.instr_pc), 32'd4);
        chk("halt_word_instr", bus.instr, 32'h0800025A);
        cyc();
        cyc();
        chk("halt_noen",  32'(bus.mem_en), 32'd0);
        chk("halt_ldrdy", 32'(bus.ld_ready), 32'd1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'h10;
        bus.ld_data  = 8'hAA;
        #1;
        chk("ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("ld_en",    32'(bus.mem_en), 32'd1);
        chk("ld_we",    32'(bus.mem_we), 32'd1);
        chk("ld_addr",  32'(bus.mem_addr), 32'h10);
        chk("ld_wdata", 32'(bus.mem_wdata), 32'hAA);
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
        cyc();
        bus.ld_valid = 1'b0;
        #1;
        chk("ld_idle_we",    32'(bus.mem_we), 32'd0);
        chk("ld_idle_wdata", 32'(bus.mem_wdata), 32'd0);
        bus.run            = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h10;
        bus.ld_valid       = 1'b1;
        bus.ld_addr        = 8'h20;
        bus.ld_data        = 8'h55;
        #1;
        chk("race_ldrdy", 32'(bus.ld_ready), 32'd0);
        chk("race_we",    32'(bus.mem_we), 32'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.ld_valid       = 1'b0;
        bus.instr_ready    = 1'b0;
        wait_valid(10, "w10_timeout");
        chk("w10_msb", 32'(bus.instr[31:24]), 32'hAA);
        chk("w10_pc",  32'(bus.instr_pc), 32'h10);

        // Asynchronous reset while holding a word with a loader request pending.
        cyc();
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        bus.ld_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_instr", bus.instr, 32'd0);
        chk("arst_pc",    32'(bus.instr_pc), 32'd0);
        chk("arst_en",    32'(bus.mem_en), 32'd0);
        chk("arst_we",    32'(bus.mem_we), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_ldrdy", 32'(bus.ld_ready), 32'd0);
        chk("post_we",    32'(bus.mem_we), 32'd0);
        cyc();
        bus.ld_valid = 1'b0;
        chk("post_en",   32'(bus.mem_en), 32'd1);
        chk("post_addr", 32'(bus.mem_addr), 32'd0);

        // Randomized phase: random back-pressure and redirects, word-level model.
        exp_pc     = 8'h00;
        prev_redir = 1'b0;
        prev_unal  = 1'b0;
        idle       = 0;
        held       = 32'd0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            chk("rnd_align", 32'(bus.align_err), 32'(prev_unal));
            if (prev_redir) chk("rnd_flush", 32'(bus.instr_valid), 32'd0);
            if (bus.instr_valid === 1'b1) begin
                chk("rnd_pc",    32'(bus.instr_pc), 32'(exp_pc));
                chk("rnd_instr", bus.instr, word_at(exp_pc));
                idle = 0;
            end else begin
                idle++;
                if (idle == 200) chk("rnd_live", 32'(bus.instr_valid), 32'd1);
            end
            bus.instr_ready    = 1'($urandom_range(0, 1));
            redir              = ($urandom_range(0, 11) == 0);
            rpc                = 8'($urandom);
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            if (bus.instr_valid === 1'b1 && bus.instr_ready) exp_pc = exp_pc + 8'd4;
            if (redir) exp_pc = {rpc[7:2], 2'b00};
            prev_redir = redir;
            prev_unal  = redir && (rpc[1:0] != 2'b00);
            held       = bus.instr;
        end
        bus.redirect_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the byte-wide instruction memory (256 x 8-bit, big-endian words). It owns the fetch PC, issues four byte reads per instruction on a single synchronous byte port, and assembles them into a 32-bit word. It presents each word to the IF/ID stage with a valid/ready handshake and handles branch redirects. While fetch is halted, the same memory port is shared with a program loader for writes.

Parameters:
ADDR_W, 8, byte address width (256 locations)
RESET_PC, 8'h00, fetch PC after reset (word-aligned)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = fetch enabled, 0 = halt at the next word boundary
redirect_valid  in  1  branch/jump redirect pulse
redirect_pc  in  8  redirect target; bits [1:0] ignored
instr_valid  out  1  instr/instr_pc hold a complete word
instr_ready  in  1  downstream accepts the word
instr  out  32  assembled instruction {b0,b1,b2,b3}
instr_pc  out  8  byte address of b0
align_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0
mem_en  out  1  memory port access this cycle
mem_we  out  1  write strobe (loader only)
mem_addr  out  8  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, valid the cycle after mem_en & !mem_we
ld_valid  in  1  loader write request
ld_addr  in  8  loader byte address
ld_data  in  8  loader byte
ld_ready  out  1  loader write accepted this cycle

Behaviour:
- Reset (async, rst_n=0): state=HALT, pc=RESET_PC. instr_valid=0, instr=0, instr_pc=0, align_err=0, mem_en=0, mem_we=0.
- States:
  - HALT -> FETCH when run=1.
  - FETCH -> HOLD after byte 3 is captured.
  - HOLD -> FETCH on handshake when run=1.
  - HOLD -> HALT on handshake when run=0.
- FETCH timing, first issue in cycle T:
  - mem_en=1, mem_we=0, mem_addr=pc+k in cycle T+k, k=0..3.
  - Byte k is captured from mem_rdata at the end of T+k+1.
  - instr_valid=1 from cycle T+5. Latency is 5 cycles; throughput is 1 word per 6 cycles minimum.
- HOLD: instr, instr_pc and instr_valid stay stable until instr_valid & instr_ready. On the handshake edge: pc := pc+4 (mod 256, so 252 -> 0) and instr_valid := 0. The next FETCH issues in the following cycle.
- run deasserted mid-FETCH: the current word completes and is delivered, then the block halts. run=0 never truncates a word.
- Redirect (any state except HALT), in cycle C:
  - Bytes in flight are discarded.
  - instr_valid=0 from C+1.
  - pc := {redirect_pc[7:2],2'b00}.
  - FETCH issues the new pc from C+1, provided run=1.
- Redirect in HALT: only loads pc.
- Redirect in the same cycle as a handshake: the word is consumed and the redirect target wins over pc+4.
- align_err pulses in C+1 when redirect_pc[1:0] != 0; the target is still applied aligned.
- Loader:
  - ld_ready = (state==HALT) & !run.
  - On ld_valid & ld_ready: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, all combinational in the same cycle.
  - Otherwise mem_wdata=0 and mem_we=0.
  - Loader writes never overlap fetch reads.
- run rising in the same cycle as ld_valid: ld_ready=0 and fetch wins.
- Reset mid-fetch: everything is discarded and the block returns to HALT with pc=RESET_PC.

Decomposition:
- Shared package imem_pkg:
  - state encoding (HALT, FETCH, HOLD)
  - INSTR_BYTES=4
  - PC_INC=4
  - RESET_PC default
- No sub-module required. The byte-assembly shift register plus the 2-bit issue and capture counters stay inline.

Test Plan:
- Memory model bytes [0..7] = E8 1F 1F FD 08 00 02 5A; reset; run=1 at cycle 0, instr_ready=1 -> mem_addr 0,1,2,3 in cycles 1-4; instr=32'hE81F1FFD, instr_pc=0 valid in cycle 6; next instr=32'h0800025A, instr_pc=4.
- instr_ready=0 for 10 cycles after the first word -> instr/instr_valid stable throughout, no mem_en; ready=1 -> pc advances to 4 and the next fetch starts the following cycle.
- redirect_valid with redirect_pc=8'h42 during byte 2 of a fetch -> instr_valid stays 0, mem_addr=0x40 next cycle, align_err pulses once, delivered instr_pc=0x40.
- Set pc=252 via redirect; fetch and consume -> mem_addr 252..255, then the next word is fetched from address 0 (wrap).
- run=0 mid-FETCH -> word delivered, then HALT; loader writes 0xAA to address 0x10 -> ld_ready=1, mem_we=1, mem_addr=0x10 that cycle; run=1 with a redirect to 0x10 -> instr[31:24]=0xAA.
- Assert rst_n=0 during HOLD with ld_valid=1 -> outputs zero immediately (async); after release, state=HALT, pc=0, ld_valid is not accepted while run=1.
